seq_divider: RTL and testbench

- Iterative radix-2 restoring divider; the inverse partner of the team's multiplier datapath.
- Produces quotient and remainder one bit per clock using a WIDTH-bit subtract/compare each cycle.
- Intended as the DIV/REM functional unit beside the multiplier.
- Signed and unsigned modes; divide-by-zero and overflow results follow RISC-V M-extension rules.

---
 rtl/seq_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider (DIV/REM unit).
// One quotient bit per clock; signed mode works on magnitudes and fixes the
// signs in a final cycle. Divide-by-zero and MIN/-1 follow RISC-V M rules.
//
// Build option: DIV_EARLY_ZERO_EN
//   defined   - a zero divisor goes straight from IDLE to FIX (2-edge latency)
//   undefined - every operation takes WIDTH+2 edges, zero divisor included
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_start; results of the last operation held
// DIV   | one shift/subtract iteration per cycle, WIDTH cycles
// FIX   | apply signs / divide-by-zero override, register results, pulse done
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, becomes quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] orig_q, orig_d;     // untouched dividend for the /0 remainder
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Operand conditioning and one restoring-division step.
    // Because rem < divisor holds between steps, shifted < 2*divisor, so a
    // WIDTH+1 bit difference is enough and its MSB is a true sign bit.
    always_comb begin
        a_neg   = i_signed & i_dividend[WIDTH-1];
        b_neg   = i_signed & i_divisor[WIDTH-1];
        a_mag   = a_neg ? (~i_dividend + ONE) : i_dividend;
        b_mag   = b_neg ? (~i_divisor + ONE) : i_divisor;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    // State register and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            orig_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update for each FSM state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    orig_d  = i_dividend;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    zero_d  = (i_divisor == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
`ifdef DIV_EARLY_ZERO_EN
                    if (i_divisor == '0) begin
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_DIV: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d = qneg_q ? (~dvd_q + ONE) : dvd_q;
                rmd_d = rneg_q ? (~rem_q + ONE) : rem_q;
                dbz_d = 1'b0;
                if (zero_q) begin
                    quo_d = '1;
                    rmd_d = orig_q;
                    dbz_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;
    assign o_quotient    = quo_q;
    assign o_remainder   = rmd_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed cases from the
// divider's contract followed by randomized operands against an arithmetic
// reference model.
module tb_seq_divider;

    localparam int W = 32;
    localparam int LAT_FULL = W + 2;
`ifdef DIV_EARLY_ZERO_EN
    localparam int LAT_ZERO = 2;
`else
    localparam int LAT_ZERO = W + 2;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic         i_signed;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_signed     (i_signed),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Drive a start request; returns #1 after the accepting edge E0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        i_dividend = a;
        i_divisor  = b;
        i_signed   = s;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Sample once per cycle from E0 until o_done; edges counts E0 as 1.
    // inject_at>0 pulses a 9/2 start request while the operation is busy.
    task automatic wait_done(input int inject_at, output int edges, output int busy_cyc);
        edges    = 1;
        busy_cyc = 0;
        while (!o_done && edges < 100) begin
            if (o_busy) busy_cyc++;
            if (inject_at > 0 && edges == inject_at) begin
                i_dividend = 32'd9;
                i_divisor  = 32'd2;
                i_signed   = 1'b0;
                i_start    = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(posedge i_clk);
            #1;
            edges++;
        end
        i_start = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz);
        int edges, busy_cyc, exp_lat;
        exp_lat = (b == 0) ? LAT_ZERO : LAT_FULL;
        start_op(a, b, s);
        wait_done(0, edges, busy_cyc);
        chk({tag, " latency"}, 64'(edges), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_lat - 1));
        chk({tag, " busy_at_done"}, 64'(o_busy), 64'(0));
        chk({tag, " quotient"}, 64'(o_quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(o_remainder), 64'(er));
        chk({tag, " div_by_zero"}, 64'(o_div_by_zero), 64'(edz));
        @(posedge i_clk);
        #1;
        chk({tag, " done_pulse_width"}, 64'(o_done), 64'(0));
        chk({tag, " quotient_held"}, 64'(o_quotient), 64'(eq));
    endtask

    initial begin
        int edges, busy_cyc;
        logic any_done;
        logic [W-1:0] a, b, eq, er;
        logic s, edz;

        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset busy", 64'(o_busy), 64'(0));
        chk("reset done", 64'(o_done), 64'(0));
        chk("reset quotient", 64'(o_quotient), 64'(0));
        chk("reset remainder", 64'(o_remainder), 64'(0));
        chk("reset dbz", 64'(o_div_by_zero), 64'(0));
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        run_check("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_check("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_check("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_check("sMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_check("uMAX/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_check("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        run_check("u10/20", 32'd10, 32'd20, 1'b0, 32'd0, 32'd10, 1'b0);

        // Start while busy is ignored; then a start in the done cycle is accepted.
        start_op(32'd50, 32'd3, 1'b0);
        wait_done(10, edges, busy_cyc);
        chk("busy_start latency", 64'(edges), 64'(LAT_FULL));
        chk("busy_start quotient", 64'(o_quotient), 64'(16));
        chk("busy_start remainder", 64'(o_remainder), 64'(2));
        start_op(32'd9, 32'd2, 1'b0);
        chk("b2b old_result_held", 64'(o_quotient), 64'(16));
        chk("b2b busy_after_accept", 64'(o_busy), 64'(1));
        chk("b2b done_single_pulse", 64'(o_done), 64'(0));
        wait_done(0, edges, busy_cyc);
        chk("b2b latency", 64'(edges), 64'(LAT_FULL));
        chk("b2b quotient", 64'(o_quotient), 64'(4));
        chk("b2b remainder", 64'(o_remainder), 64'(1));
        @(posedge i_clk);
        #1;

        // Asynchronous reset in the middle of the iterations.
        start_op(32'd123456, 32'd789, 1'b0);
        repeat (15) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midreset busy", 64'(o_busy), 64'(0));
        chk("midreset done", 64'(o_done), 64'(0));
        chk("midreset quotient", 64'(o_quotient), 64'(0));
        chk("midreset remainder", 64'(o_remainder), 64'(0));
        chk("midreset dbz", 64'(o_div_by_zero), 64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            any_done = any_done | o_done | o_busy;
        end
        chk("midreset no_done", 64'(any_done), 64'(0));
        run_check("u7/7", 32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                3:       b = 32'd0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er, edz);
            run_check($sformatf("rand%0d", i), a, b, s, eq, er, edz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
